// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundle of every non-clock/reset signal of the fetch stage.
//
// Signal summary (direction seen from the fetch unit, modport master):
//   rom_addr_out      out  ADDR_W  byte address to the instruction ROM
//   rom_data_in       in   32      ROM word at rom_addr_out (combinational)
//   redirect_valid_in in   1       one-cycle pulse: load a new fetch PC
//   redirect_pc_in    in   ADDR_W  redirect target byte address
//   if_valid_out      out  1       output slot holds an instruction
//   if_ready_in       in   1       decode accepts the slot this cycle
//   if_instr_out      out  32      registered instruction word
//   if_pc_out         out  ADDR_W  byte address of if_instr_out
//   fault_out         out  1       unit is in FAULT
//   fault_cause_out   out  2       00 none, 01 misaligned redirect, 10 illegal
//   fault_pc_out      out  ADDR_W  offending address
//
// modport slave is the environment side (ROM, branch unit, decode).
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 24
);
   logic [ADDR_W-1:0] rom_addr_out;
   logic [31:0]       rom_data_in;
   logic              redirect_valid_in;
   logic [ADDR_W-1:0] redirect_pc_in;
   logic              if_valid_out;
   logic              if_ready_in;
   logic [31:0]       if_instr_out;
   logic [ADDR_W-1:0] if_pc_out;
   logic              fault_out;
   logic [1:0]        fault_cause_out;
   logic [ADDR_W-1:0] fault_pc_out;

   modport master (
      output rom_addr_out,
      input  rom_data_in,
      input  redirect_valid_in,
      input  redirect_pc_in,
      output if_valid_out,
      input  if_ready_in,
      output if_instr_out,
      output if_pc_out,
      output fault_out,
      output fault_cause_out,
      output fault_pc_out
   );

   modport slave (
      input  rom_addr_out,
      output rom_data_in,
      output redirect_valid_in,
      output redirect_pc_in,
      input  if_valid_out,
      output if_ready_in,
      input  if_instr_out,
      input  if_pc_out,
      input  fault_out,
      input  fault_cause_out,
      input  fault_pc_out
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage of the beleg RISC-V core. Owns the fetch PC, addresses the
// combinational instruction ROM, captures each word with its PC into a
// one-entry output slot and hands it to decode over valid/ready. Redirects
// load a new PC; misaligned targets and non-32-bit encodings raise a fault.
//
// Ports:
//   clk_in    in  1  system clock, rising edge
//   rst_n_in  in  1  asynchronous active-low reset
//   bus       instr_fetch_unit_if.master (ROM, redirect, decode, fault)
//
// State table:
//   state    | meaning
//   ST_RUN   | fetching one word per cycle while the slot is free
//   ST_FAULT | fetch halted, fault reported; only a redirect or reset leaves
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                ADDR_W   = 24,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   instr_fetch_unit_if.master  bus
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

   state_t            state_q,    state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              valid_q,    valid_d;
   logic [31:0]       instr_q,    instr_d;
   logic [ADDR_W-1:0] pc_q,       pc_d;
   logic [1:0]        cause_q,    cause_d;
   logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

   logic slot_free;
   logic word_is_32b;
   logic redirect_aligned;

   assign slot_free        = !valid_q || bus.if_ready_in;
   assign word_is_32b      = (bus.rom_data_in[1:0] == 2'b11);
   assign redirect_aligned = (bus.redirect_pc_in[1:0] == 2'b00);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         pc_q       <= '0;
         cause_q    <= CAUSE_NONE;
         fault_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         cause_q    <= cause_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      cause_d    = cause_q;
      fault_pc_d = fault_pc_q;

      if (bus.redirect_valid_in) begin
         // Redirect wins over fetch, stall and fault; any slot contents are
         // stale, even if decode handshakes in this same cycle.
         valid_d = 1'b0;
         if (redirect_aligned) begin
            fetch_pc_d = bus.redirect_pc_in;
            state_d    = ST_RUN;
            cause_d    = CAUSE_NONE;
         end else if (state_q == ST_RUN) begin
            // Only the first fault is recorded; a misaligned redirect while
            // already faulted leaves the original cause and address.
            state_d    = ST_FAULT;
            cause_d    = CAUSE_MISALIGN;
            fault_pc_d = bus.redirect_pc_in;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (slot_free) begin
                  if (word_is_32b) begin
                     instr_d    = bus.rom_data_in;
                     pc_d       = fetch_pc_q;
                     valid_d    = 1'b1;
                     fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                  end else begin
                     // Slot is free, so any word held there is being taken
                     // this cycle; just stop presenting anything new.
                     valid_d    = 1'b0;
                     state_d    = ST_FAULT;
                     cause_d    = CAUSE_ILLEGAL;
                     fault_pc_d = fetch_pc_q;
                  end
               end
            end
            ST_FAULT: begin
               valid_d = 1'b0;
            end
            default: begin
               state_d = ST_RUN;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.rom_addr_out    = fetch_pc_q;
   assign bus.if_valid_out    = valid_q;
   assign bus.if_instr_out    = instr_q;
   assign bus.if_pc_out       = pc_q;
   assign bus.fault_out       = (state_q == ST_FAULT);
   assign bus.fault_cause_out = cause_q;
   assign bus.fault_pc_out    = fault_pc_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the beleg RISC-V core. Owns the program counter and drives the byte address of the combinational 2^24 x 8 instruction ROM, which returns a 32-bit little-endian word at addr..addr+3 in the same cycle.
- Registers each fetched word and its PC into a one-entry output slot.
- Hands the slot to decode through a valid/ready handshake.
- Accepts redirects (branch/jump) and flags fetch faults (misaligned target, 16-bit compressed encoding).

Parameters:
- ADDR_W, 24, byte-address width of the instruction ROM.
- RESET_PC, 24'h000000, first fetch address after reset; must be 4-byte aligned.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- rom_addr_out  output  ADDR_W  byte address to the ROM; always equals the fetch_pc register.
- rom_data_in  input  32  instruction word from the ROM, valid combinationally for rom_addr_out.
- redirect_valid_in  input  1  one-cycle pulse: load a new fetch PC.
- redirect_pc_in  input  ADDR_W  redirect target byte address.
- if_valid_out  output  1  output slot holds an instruction for decode.
- if_ready_in  input  1  decode accepts the slot this cycle.
- if_instr_out  output  32  registered instruction word.
- if_pc_out  output  ADDR_W  byte address of if_instr_out.
- fault_out  output  1  unit is in FAULT state.
- fault_cause_out  output  2  2'b00 none, 2'b01 misaligned redirect, 2'b10 compressed/illegal encoding.
- fault_pc_out  output  ADDR_W  offending address.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC; if_valid_out=0; if_instr_out=0; if_pc_out=0; fault_out=0; fault_cause_out=0; fault_pc_out=0; state=RUN.
- Reset asserted mid-operation discards the slot immediately, with no partial outputs.
- States are RUN and FAULT.
- slot_free = !if_valid_out || if_ready_in.
- RUN, no redirect, slot_free, rom_data_in[1:0]==2'b11:
  - load if_instr_out=rom_data_in and if_pc_out=fetch_pc;
  - set if_valid_out=1;
  - fetch_pc += 4, modulo 2^ADDR_W (24'hFFFFFC wraps to 0).
- RUN, no redirect, slot_free, rom_data_in[1:0]!=2'b11:
  - do not load the slot; if_valid_out=0 (a slot accepted this cycle still completes);
  - enter FAULT with cause 2'b10 and fault_pc_out=fetch_pc;
  - fetch_pc holds.
- RUN, !slot_free (stall): all registers hold. if_instr_out and if_pc_out must stay stable while if_valid_out=1 && !if_ready_in.
- Redirect, in any state. It has priority over fetch, stall and fault:
  - if_valid_out=0, flushing the slot even if if_ready_in=1. Decode treats a same-cycle handshake as void.
  - If redirect_pc_in[1:0]==0: fetch_pc=redirect_pc_in; state=RUN; fault_out=0; fault_cause_out=0.
  - Otherwise: state=FAULT, cause 2'b01, fault_pc_out=redirect_pc_in; fetch_pc unchanged.
- Redirect latency: the first instruction from the target appears on if_valid_out 2 cycles after the redirect edge (address cycle, then capture).
- Steady-state throughput is one instruction per cycle. After reset release, the first instruction is valid at the first clock edge.
- FAULT state:
  - fault_out=1; if_valid_out=0; no fetching; fetch_pc holds.
  - Leaves FAULT only on a redirect (trap vector) or reset.
- No new fault is raised while already in FAULT; the first cause is kept.

Test Plan:
- Reset release, ROM words 0x00000013 at 0x0, 0x00100093 at 0x4, if_ready_in=1 -> if_valid_out rises at 1st edge with if_pc_out=0x0, if_instr_out=0x00000013; next cycle if_pc_out=0x4, if_instr_out=0x00100093.
- Hold if_ready_in=0 for 3 cycles after the first valid -> if_instr_out and if_pc_out frozen at 0x0; rom_addr_out stays 0x4; on release, PCs 0x0, 0x4, 0x8 appear with no gap and no duplicate.
- redirect_valid_in=1, redirect_pc_in=0x000100 while if_valid_out=1 and if_ready_in=1 -> if_valid_out=0 next cycle; if_pc_out=0x100 two cycles after the redirect.
- redirect_pc_in=0x000102 -> fault_out=1, fault_cause_out=2'b01, fault_pc_out=0x102; if_valid_out stays 0; a later redirect to 0x200 clears the fault and fetches 0x200.
- ROM word 0x00004501 (compressed) at 0x8 -> fault_cause_out=2'b10, fault_pc_out=0x8; instructions at 0x0 and 0x4 delivered normally.
- Redirect to 0xFFFFFC -> word at 0xFFFFFC is delivered, then if_pc_out=0x000000 (wrap).
